refill_rd_arbiter: RTL and testbench

// - Shares one AXI read-burst channel (axi_shim rd_* port) between NumReq refill requesters
//   (I$ miss path, instruction prefetcher, ...).
// - Round-robin arbitration, one burst in flight at a time.
// - Holds each accepted request stable on the shim until granted, then steers returning

---
 rtl/refill_rd_arbiter_if.sv | 29 ++
 rtl/refill_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_refill_rd_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/refill_rd_arbiter_if.sv
// Read-burst channel between refill_rd_arbiter (master) and axi_shim (slave).
// Request side: req/gnt handshake carrying addr, blen and id.
// Return side: valid beats carrying last, data and the returning id (rtn_id).
interface refill_rd_arbiter_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned BlenWidth = 2,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64
);
    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] addr;
    logic [BlenWidth-1:0] blen;
    logic [IdWidth-1:0]   id;
    logic                 valid;
    logic                 last;
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   rtn_id;

    modport master (
        output req, addr, blen, id,
        input  gnt, valid, last, data, rtn_id
    );

    modport slave (
        input  req, addr, blen, id,
        output gnt, valid, last, data, rtn_id
    );
endinterface

// File: rtl/refill_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read-burst channel between NumReq refill
// requesters. One burst in flight; returning beats are steered to the owner by ID.
// Grant, beat steering and error pulses are combinational; every output is forced
// to zero while rst_i is high.
module refill_rd_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned BlenWidth = 2,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    output logic [NumReq-1:0]           req_gnt_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq*BlenWidth-1:0] req_blen_i,
    refill_rd_arbiter_if.master         axi,
    output logic [NumReq-1:0]           rtrn_valid_o,
    output logic                        rtrn_last_o,
    output logic [63:0]                 rtrn_data_o,
    output logic                        busy_o,
    output logic                        err_o
);
    localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [BlenWidth-1:0] CntMax = '1;
    localparam logic [PtrWidth-1:0] LastReq = PtrWidth'(NumReq - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [BlenWidth-1:0] blen_q, blen_d;
    logic [BlenWidth-1:0] cnt_q, cnt_d;
    logic [PtrWidth-1:0]  owner_q, owner_d;
    logic [PtrWidth-1:0]  rr_q, rr_d;

    logic [PtrWidth-1:0]  sel;
    logic                 found;
    logic                 beat_own;
    logic [NumReq-1:0]    gnt_c;
    logic [NumReq-1:0]    rtrn_valid_c;
    logic                 rd_req_c;
    logic                 rtrn_last_c;
    logic                 err_c;

    logic [AddrWidth-1:0] req_addr [NumReq];
    logic [BlenWidth-1:0] req_blen [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign req_addr[g] = req_addr_i[g*AddrWidth +: AddrWidth];
        assign req_blen[g] = req_blen_i[g*BlenWidth +: BlenWidth];
    end

    // Round-robin pick: first asserted request at or above rr_q, wrapping
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && req_i[PtrWidth'((32'(rr_q) + i) % NumReq)]) begin
                found = 1'b1;
                sel   = PtrWidth'((32'(rr_q) + i) % NumReq);
            end
        end
    end

    assign beat_own = axi.valid && (axi.rtn_id == IdWidth'(owner_q));

    // Next-state and combinational outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        blen_d       = blen_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        gnt_c        = '0;
        rtrn_valid_c = '0;
        rd_req_c     = 1'b0;
        rtrn_last_c  = 1'b0;
        err_c        = 1'b0;

        unique case (state_q)
            IDLE: begin
                err_c = axi.valid;
                if (found) begin
                    gnt_c[sel] = 1'b1;
                    addr_d     = req_addr[sel];
                    blen_d     = req_blen[sel];
                    owner_d    = sel;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                rd_req_c = 1'b1;
                err_c    = axi.valid;
                if (axi.gnt) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (axi.valid && !beat_own) begin
                    err_c = 1'b1;
                end
                if (beat_own) begin
                    rtrn_valid_c[owner_q] = 1'b1;
                    rtrn_last_c           = axi.last;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (axi.last) begin
                        err_c   = (cnt_q != blen_q);
                        rr_d    = (owner_q == LastReq) ? '0 : owner_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst context registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            blen_q  <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            blen_q  <= blen_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign req_gnt_o    = rst_i ? '0 : gnt_c;
    assign axi.req      = !rst_i && rd_req_c;
    assign axi.addr     = rst_i ? '0 : addr_q;
    assign axi.blen     = rst_i ? '0 : blen_q;
    assign axi.id       = rst_i ? '0 : IdWidth'(owner_q);
    assign rtrn_valid_o = rst_i ? '0 : rtrn_valid_c;
    assign rtrn_last_o  = !rst_i && rtrn_last_c;
    assign rtrn_data_o  = rst_i ? '0 : axi.data;
    assign busy_o       = !rst_i && (state_q != IDLE);
    assign err_o        = !rst_i && err_c;
endmodule

// File: tb/tb_refill_rd_arbiter.sv
// Bench for refill_rd_arbiter: directed scenarios plus randomized bursts against a
// transaction-level round-robin model. The bench plays both requesters and the shim.
module tb_refill_rd_arbiter;
    localparam int unsigned NumReq    = 2;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned BlenWidth = 2;
    localparam int unsigned IdWidth   = 4;
    localparam int          NumBursts = 60;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NumReq-1:0]           req;
    logic [NumReq-1:0]           req_gnt;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*BlenWidth-1:0] req_blen;
    logic [NumReq-1:0]           rtrn_valid;
    logic                        rtrn_last;
    logic [63:0]                 rtrn_data;
    logic                        busy;
    logic                        err;

    int errors = 0;
    int checks = 0;

    // model state
    logic [NumReq-1:0]    pend;
    logic [AddrWidth-1:0] addr_m [NumReq];
    logic [BlenWidth-1:0] blen_m [NumReq];
    int                   rr_m;
    int                   own;
    int                   nb;
    logic [AddrWidth-1:0] ea;
    logic [BlenWidth-1:0] eb;

    refill_rd_arbiter_if #(
        .AddrWidth(AddrWidth), .BlenWidth(BlenWidth), .IdWidth(IdWidth), .DataWidth(64)
    ) axi_if ();

    refill_rd_arbiter #(
        .NumReq(NumReq), .AddrWidth(AddrWidth), .BlenWidth(BlenWidth), .IdWidth(IdWidth)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_gnt_o    (req_gnt),
        .req_addr_i   (req_addr),
        .req_blen_i   (req_blen),
        .axi          (axi_if),
        .rtrn_valid_o (rtrn_valid),
        .rtrn_last_o  (rtrn_last),
        .rtrn_data_o  (rtrn_data),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first pending requester at or after rr, wrapping
    function automatic int pick(input int rr, input logic [NumReq-1:0] m);
        int res;
        res = -1;
        for (int i = 0; i < NumReq; i++) begin
            if (res < 0 && m[(rr + i) % NumReq]) res = (rr + i) % NumReq;
        end
        return res;
    endfunction

    task automatic set_req(input int k, input logic [AddrWidth-1:0] a, input logic [BlenWidth-1:0] bl);
        req_addr[k*AddrWidth +: AddrWidth] = a;
        req_blen[k*BlenWidth +: BlenWidth] = bl;
    endtask

    task automatic new_req(input int k);
        pend[k]   = 1'b1;
        addr_m[k] = {$urandom, $urandom};
        blen_m[k] = BlenWidth'($urandom);
        set_req(k, addr_m[k], blen_m[k]);
    endtask

    // Idle cycle in which requester exp_own must be granted
    task automatic grant_cycle(input int exp_own, input string tag);
        #1;
        check_eq({tag, "_gnt"}, 64'(req_gnt), 64'(1) << exp_own);
        check_eq({tag, "_busy_idle"}, 64'(busy), 64'(0));
        cyc();
    endtask

    // Address phase: shim grants on cycle waits (0-based)
    task automatic addr_phase(input int waits, input int o, input logic [AddrWidth-1:0] a,
                              input logic [BlenWidth-1:0] bl, input string tag);
        for (int w = 0; w <= waits; w++) begin
            axi_if.gnt = (w == waits);
            #1;
            check_eq({tag, "_rdreq"}, 64'(axi_if.req), 64'(1));
            check_eq({tag, "_addr"}, 64'(axi_if.addr), 64'(a));
            check_eq({tag, "_blen"}, 64'(axi_if.blen), 64'(bl));
            check_eq({tag, "_id"}, 64'(axi_if.id), 64'(o));
            check_eq({tag, "_nogntaddr"}, 64'(req_gnt), 64'(0));
            cyc();
        end
        axi_if.gnt = 1'b0;
    endtask

    // One return beat from the shim, with expected steering and error
    task automatic beat(input logic [IdWidth-1:0] rid, input logic last,
                        input logic [NumReq-1:0] exp_valid, input logic exp_err, input string tag);
        logic [63:0] d;
        d = {$urandom, $urandom};
        axi_if.valid  = 1'b1;
        axi_if.rtn_id = rid;
        axi_if.last   = last;
        axi_if.data   = d;
        #1;
        check_eq({tag, "_valid"}, 64'(rtrn_valid), 64'(exp_valid));
        check_eq({tag, "_last"}, 64'(rtrn_last), 64'(last && (exp_valid != '0)));
        check_eq({tag, "_data"}, rtrn_data, d);
        check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
        check_eq({tag, "_nogntbeat"}, 64'(req_gnt), 64'(0));
        cyc();
        axi_if.valid = 1'b0;
        axi_if.last  = 1'b0;
    endtask

    // Gap cycle in DATA with no beat
    task automatic quiet(input string tag);
        axi_if.valid = 1'b0;
        #1;
        check_eq({tag, "_valid"}, 64'(rtrn_valid), 64'(0));
        check_eq({tag, "_err"}, 64'(err), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(1));
        cyc();
    endtask

    // Idle cycle after a burst with no requests pending
    task automatic expect_idle(input string tag);
        #1;
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_rdreq"}, 64'(axi_if.req), 64'(0));
        cyc();
    endtask

    initial begin
        rst           = 1'b1;
        req           = '0;
        req_addr      = '0;
        req_blen      = '0;
        axi_if.gnt    = 1'b0;
        axi_if.valid  = 1'b0;
        axi_if.last   = 1'b0;
        axi_if.data   = '0;
        axi_if.rtn_id = '0;
        pend          = '0;
        cyc();

        // Outputs held at zero while reset is high, even with activity on inputs
        req = 2'b01;
        set_req(0, 64'h8000_0040, 2'd1);
        axi_if.valid = 1'b1;
        axi_if.data  = 64'hDEAD_BEEF_0000_0001;
        #1;
        check_eq("rst_gnt", 64'(req_gnt), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_rdreq", 64'(axi_if.req), 64'(0));
        check_eq("rst_addr", 64'(axi_if.addr), 64'(0));
        check_eq("rst_rvalid", 64'(rtrn_valid), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_data", rtrn_data, 64'(0));
        cyc();
        rst          = 1'b0;
        req          = '0;
        axi_if.valid = 1'b0;

        // Both requesting continuously, blen 0: grants rotate 0,1,0,1
        set_req(0, 64'h0000_1000, 2'd0);
        set_req(1, 64'h0000_2000, 2'd0);
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            own = n % 2;
            grant_cycle(own, "rot");
            addr_phase(0, own, (own == 1) ? 64'h0000_2000 : 64'h0000_1000, 2'd0, "rot");
            beat(IdWidth'(own), 1'b1, NumReq'(1) << own, 1'b0, "rot_beat");
        end
        req = '0;
        expect_idle("rot");

        // Single requester 0, two beats, shim grants on second address cycle
        req = 2'b01;
        set_req(0, 64'h8000_0040, 2'd1);
        grant_cycle(0, "single");
        req = '0;
        addr_phase(1, 0, 64'h8000_0040, 2'd1, "single");
        beat(4'd0, 1'b0, 2'b01, 1'b0, "single_b0");
        beat(4'd0, 1'b1, 2'b01, 1'b0, "single_b1");
        expect_idle("single");

        // Stray beat in ADDR, wrong-ID beat in DATA; rr points at 1 but only 0 requests
        req = 2'b01;
        set_req(0, 64'h1234_5678_9ABC_DE00, 2'd1);
        grant_cycle(0, "perr");
        req = '0;
        beat(4'd0, 1'b0, 2'b00, 1'b1, "addr_beat");
        addr_phase(0, 0, 64'h1234_5678_9ABC_DE00, 2'd1, "perr");
        beat(4'd1, 1'b1, 2'b00, 1'b1, "id_mis");
        beat(4'd0, 1'b0, 2'b01, 1'b0, "perr_b0");
        beat(4'd0, 1'b1, 2'b01, 1'b0, "perr_b1");
        expect_idle("perr");

        // Early last: blen 1 but last on first beat
        req = 2'b01;
        set_req(0, 64'h0000_0000_0000_0FC0, 2'd1);
        grant_cycle(0, "early");
        req = '0;
        addr_phase(0, 0, 64'h0000_0000_0000_0FC0, 2'd1, "early");
        beat(4'd0, 1'b1, 2'b01, 1'b1, "early_last");
        expect_idle("early");

        // Reset mid-burst after one of two beats, then a stray beat
        req = 2'b01;
        set_req(0, 64'hFFFF_0000_0000_0040, 2'd1);
        grant_cycle(0, "mrst");
        req = '0;
        addr_phase(0, 0, 64'hFFFF_0000_0000_0040, 2'd1, "mrst");
        beat(4'd0, 1'b0, 2'b01, 1'b0, "mrst_b0");
        rst = 1'b1;
        #1;
        check_eq("mrst_busy_in", 64'(busy), 64'(0));
        check_eq("mrst_addr_in", 64'(axi_if.addr), 64'(0));
        check_eq("mrst_rdreq_in", 64'(axi_if.req), 64'(0));
        cyc();
        rst = 1'b0;
        #1;
        check_eq("mrst_busy_after", 64'(busy), 64'(0));
        check_eq("mrst_rdreq_after", 64'(axi_if.req), 64'(0));
        beat(4'd0, 1'b1, 2'b00, 1'b1, "mrst_stray");

        // Randomized bursts against the round-robin model
        rr_m = 0;
        pend = '0;
        for (int b = 0; b < NumBursts; b++) begin
            for (int k = 0; k < NumReq; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) new_req(k);
            end
            if (pend == '0) new_req(int'($urandom_range(NumReq - 1, 0)));
            req = pend;
            own = pick(rr_m, pend);
            ea  = addr_m[own];
            eb  = blen_m[own];
            grant_cycle(own, "rnd");
            pend[own] = 1'b0;
            for (int k = 0; k < NumReq; k++) begin
                if (!pend[k] && $urandom_range(3, 0) == 0) new_req(k);
            end
            req = pend;
            addr_phase(int'($urandom_range(2, 0)), own, ea, eb, "rnd");
            nb = int'(eb) + 1;
            if (eb != '0 && $urandom_range(5, 0) == 0) nb = int'($urandom_range(int'(eb), 1));
            for (int i = 0; i < nb; i++) begin
                case ($urandom_range(4, 0))
                    0: quiet("rnd_gap");
                    1: beat(IdWidth'(own) ^ IdWidth'($urandom_range(15, 1)), 1'($urandom_range(1, 0)),
                            '0, 1'b1, "rnd_stray");
                    default: ;
                endcase
                beat(IdWidth'(own), (i == nb - 1), NumReq'(1) << own,
                     (i == nb - 1) && (i != int'(eb)), "rnd_beat");
            end
            rr_m = (own + 1) % NumReq;
        end
        req = '0;
        expect_idle("rnd_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
